// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit: sequences FETCH/DECODE/execute/writeback
// states, drives the datapath strobes and selects, and traps to a sticky FAULT
// state on illegal instructions, unknown state codes or memory wait timeouts.
module mc_controller #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic       rd_dst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] extop,
  output logic [1:0] pc_src,
  output logic       jal_sel,
  output logic       slt_sel,
  output logic       flag_sel,
  output logic       fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12,
    S_FAULT  = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_st;
  logic             timed_out;
  logic             r_sub;
  logic             r_slt;
  logic [1:0]       i_aluop;
  logic [1:0]       i_extop;
  logic             i_addi;

  // Memory-wait detection and per-instruction decode shared by several states
  always_comb begin
    wait_st   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timed_out = wait_st && !mem_rdy && (wait_cnt == TIMEOUT_C);
    r_slt     = (funct == FN_SLT);
    r_sub     = (funct == FN_SUBU) || r_slt;
    i_addi    = (opcode == OP_ADDI);
    i_aluop   = 2'b00;
    i_extop   = 2'b01;
    if (opcode == OP_ORI) begin
      i_aluop = 2'b10;
      i_extop = 2'b00;
    end else if (opcode == OP_LUI) begin
      i_extop = 2'b10;
    end
  end

  // Next-state and output decode; every strobe defaults to 0
  always_comb begin
    state_d  = state_q;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    iord     = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    reg_wr   = 1'b0;
    rd_dst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    extop    = 2'b00;
    pc_src   = 2'b00;
    jal_sel  = 1'b0;
    slt_sel  = 1'b0;
    flag_sel = 1'b0;
    fault    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd  = 1'b1;
        alusrcb = 2'b01;
        ir_wr   = mem_rdy;
        pc_wr   = mem_rdy;
        if (mem_rdy)        state_d = S_DECODE;
        else if (timed_out) state_d = S_FAULT;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        extop   = 2'b01;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADDU || funct == FN_SUBU || funct == FN_SLT) state_d = S_REXEC;
            else if (funct == FN_JR)                                    state_d = S_JR;
            else                                                        state_d = S_FAULT;
          end
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_ORI, OP_LUI, OP_ADDI, OP_ADDIU: state_d = S_IEXEC;
          OP_BEQ:                           state_d = S_BRANCH;
          OP_J, OP_JAL:                     state_d = S_JUMP;
          default:                          state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        extop   = 2'b01;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FAULT;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        if (mem_rdy)        state_d = S_MEMWB;
        else if (timed_out) state_d = S_FAULT;
      end
      S_MEMWB: begin
        reg_wr   = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (mem_rdy)        state_d = S_FETCH;
        else if (timed_out) state_d = S_FAULT;
      end
      S_REXEC: begin
        alusrca = 1'b1;
        aluop   = r_sub ? 2'b01 : 2'b00;
        slt_sel = r_slt;
        state_d = S_RWB;
      end
      S_RWB: begin
        reg_wr  = 1'b1;
        rd_dst  = 1'b1;
        slt_sel = r_slt;
        state_d = S_FETCH;
      end
      S_IEXEC, S_IWB: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        aluop    = i_aluop;
        extop    = i_extop;
        flag_sel = i_addi;
        reg_wr   = (state_q == S_IWB);
        state_d  = (state_q == S_IEXEC) ? S_IWB : S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pc_src  = 2'b01;
        pc_wr   = zero;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_wr   = 1'b1;
        reg_wr  = (opcode == OP_JAL);
        jal_sel = (opcode == OP_JAL);
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_src  = 2'b11;
        pc_wr   = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // State register, forced back to FETCH by reset from any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Consecutive not-ready cycles in the current memory-wait state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             wait_cnt <= '0;
    else if (wait_st && !mem_rdy && state_d == state_q) wait_cnt <= wait_cnt + 1'b1;
    else                                                 wait_cnt <= '0;
  end

  assign state = state_q;

endmodule
